ascon_permutation_ctrl: RTL and testbench

- Sequencer for the Ascon permutation datapath: p^a (initialisation/finalisation) or p^b (data processing) on one 320-bit state.
- Holds the state in a register; applies one round per cycle through the combinational chain constant_addition -> substitution_layer -> diffusion_layer, instantiated from the existing cores.
- Sits between the top-level mode FSM (absorb/squeeze/tag) and the round datapath; start/done handshake.

---
 rtl/ascon_permutation_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_ascon_permutation_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_permutation_ctrl.sv
// -----------------------------------------------------------------------------
// ascon_permutation_ctrl
//
// Purpose:
//   Sequencer for the Ascon permutation. Holds the 320-bit state in a register
//   and applies p^a (ROUNDS_A rounds) or p^b (ROUNDS_B rounds) to it, one round
//   per clock (or two rounds per clock in the unrolled build). Each round is
//   the chain constant_addition -> substitution_layer -> diffusion_layer.
//   The block sits between the mode FSM (absorb/squeeze/tag) and the round
//   datapath and talks to the mode FSM through a start/done handshake.
//
// State layout (type_state):
//   logic [0:4][63:0], element k is Ascon word x_k, so the concatenation
//   {x0, x1, x2, x3, x4} maps directly onto the packed array.
//
// Parameters:
//   ROUNDS_A  rounds for p^a, legal 1..12 (default 12)
//   ROUNDS_B  rounds for p^b, legal 1..ROUNDS_A (default 6)
//
// Ports:
//   clock_i   in   1       system clock, rising edge
//   reset_i   in   1       asynchronous active-high reset
//   start_i   in   1       permutation request, honoured in IDLE/DONE only
//   mode_i    in   1       0 = p^a, 1 = p^b; sampled with an accepted start
//   state_i   in   5x64    input state, captured on an accepted start
//   state_o   out  5x64    state register contents
//   round_o   out  4       current round-constant index (0..11)
//   busy_o    out  1       high while rounds are being applied
//   done_o    out  1       one-cycle pulse, state_o holds the permuted state
//
// Build option:
//   ASCON_PERM_UNROLL2_EN  when defined, two rounds (indices i and i+1) are
//                          chained per clock and round_o steps by 2. Both
//                          ROUNDS_A and ROUNDS_B must then be even. The final
//                          state is identical to the single-round build.
// -----------------------------------------------------------------------------

// Adds the round constant for index i_round into the low byte of x2.
module constant_addition (
    input  logic [0:4][63:0] i_state,
    input  logic [3:0]       i_round,
    output logic [0:4][63:0] o_state
);

    logic [7:0] w_const;

    // High nibble counts down from 0xF while the low nibble counts up:
    // index 0 -> 0xF0, index 11 -> 0x4B.
    assign w_const = {4'hF - i_round, i_round};

    assign o_state[0] = i_state[0];
    assign o_state[1] = i_state[1];
    assign o_state[2] = i_state[2] ^ {56'd0, w_const};
    assign o_state[3] = i_state[3];
    assign o_state[4] = i_state[4];

endmodule

// Bitsliced 5-bit Ascon S-box applied to all 64 columns in parallel.
module substitution_layer (
    input  logic [0:4][63:0] i_state,
    output logic [0:4][63:0] o_state
);

    logic [63:0] w_a0, w_a1, w_a2, w_a3, w_a4;
    logic [63:0] w_b0, w_b1, w_b2, w_b3, w_b4;

    // Input mixing
    assign w_a0 = i_state[0] ^ i_state[4];
    assign w_a1 = i_state[1];
    assign w_a2 = i_state[2] ^ i_state[1];
    assign w_a3 = i_state[3];
    assign w_a4 = i_state[4] ^ i_state[3];

    // Chi-like nonlinear step; every term reads the mixed snapshot w_a*
    assign w_b0 = w_a0 ^ (~w_a1 & w_a2);
    assign w_b1 = w_a1 ^ (~w_a2 & w_a3);
    assign w_b2 = w_a2 ^ (~w_a3 & w_a4);
    assign w_b3 = w_a3 ^ (~w_a4 & w_a0);
    assign w_b4 = w_a4 ^ (~w_a0 & w_a1);

    // Output mixing; x3 takes x2 before the final inversion
    assign o_state[0] = w_b0 ^ w_b4;
    assign o_state[1] = w_b1 ^ w_b0;
    assign o_state[2] = ~w_b2;
    assign o_state[3] = w_b3 ^ w_b2;
    assign o_state[4] = w_b4;

endmodule

// Linear diffusion: each word is XORed with two right-rotations of itself.
module diffusion_layer (
    input  logic [0:4][63:0] i_state,
    output logic [0:4][63:0] o_state
);

    // ror(x, n) is written as {x[n-1:0], x[63:n]}
    assign o_state[0] = i_state[0]
                      ^ {i_state[0][18:0], i_state[0][63:19]}
                      ^ {i_state[0][27:0], i_state[0][63:28]};
    assign o_state[1] = i_state[1]
                      ^ {i_state[1][60:0], i_state[1][63:61]}
                      ^ {i_state[1][38:0], i_state[1][63:39]};
    assign o_state[2] = i_state[2]
                      ^ {i_state[2][0],    i_state[2][63:1]}
                      ^ {i_state[2][5:0],  i_state[2][63:6]};
    assign o_state[3] = i_state[3]
                      ^ {i_state[3][9:0],  i_state[3][63:10]}
                      ^ {i_state[3][16:0], i_state[3][63:17]};
    assign o_state[4] = i_state[4]
                      ^ {i_state[4][6:0],  i_state[4][63:7]}
                      ^ {i_state[4][40:0], i_state[4][63:41]};

endmodule

module ascon_permutation_ctrl #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [0:4][63:0] state_i,
    output logic [0:4][63:0] state_o,
    output logic [3:0]       round_o,
    output logic             busy_o,
    output logic             done_o
);

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // N rounds use constant indices 12-N .. 11
    localparam logic [3:0] IDX_LAST = 4'd11;
    localparam logic [3:0] FIRST_A  = 4'(12 - ROUNDS_A);
    localparam logic [3:0] FIRST_B  = 4'(12 - ROUNDS_B);

`ifdef ASCON_PERM_UNROLL2_EN
    // Two rounds per clock: the cycle showing index 10 applies 10 and 11
    localparam logic [3:0] IDX_STEP = 4'd2;
    localparam logic [3:0] IDX_EXIT = 4'd10;
`else
    localparam logic [3:0] IDX_STEP = 4'd1;
    localparam logic [3:0] IDX_EXIT = 4'd11;
`endif

    logic [1:0]       r_fsm;
    logic [0:4][63:0] r_state;
    logic [3:0]       r_round;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic [3:0]       w_first;
    logic [0:4][63:0] w_next;

    // First round index for the requested mode and start acceptance.
    // DONE accepts exactly like IDLE so back-to-back permutations need no bubble.
    always_comb begin
        if (mode_i) begin
            w_first = FIRST_B;
        end else begin
            w_first = FIRST_A;
        end
        if (((r_fsm == S_IDLE) || (r_fsm == S_DONE)) && start_i) begin
            w_accept = 1'b1;
        end else begin
            w_accept = 1'b0;
        end
    end

    // Round datapath, first (or only) round of the cycle at index r_round
    logic [0:4][63:0] w_ca0, w_sl0, w_rnd0;

    constant_addition u_ca0 (
        .i_state (r_state),
        .i_round (r_round),
        .o_state (w_ca0)
    );

    substitution_layer u_sl0 (
        .i_state (w_ca0),
        .o_state (w_sl0)
    );

    diffusion_layer u_dl0 (
        .i_state (w_sl0),
        .o_state (w_rnd0)
    );

`ifdef ASCON_PERM_UNROLL2_EN
    // Second round of the cycle at index r_round+1
    logic [3:0]       w_round1;
    logic [0:4][63:0] w_ca1, w_sl1, w_rnd1;

    assign w_round1 = r_round + 4'd1;

    constant_addition u_ca1 (
        .i_state (w_rnd0),
        .i_round (w_round1),
        .o_state (w_ca1)
    );

    substitution_layer u_sl1 (
        .i_state (w_ca1),
        .o_state (w_sl1)
    );

    diffusion_layer u_dl1 (
        .i_state (w_sl1),
        .o_state (w_rnd1)
    );

    assign w_next = w_rnd1;
`else
    assign w_next = w_rnd0;
`endif

    // Sequencer: state register, round index, and registered busy/done flags
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_fsm   <= S_IDLE;
            r_state <= '0;
            r_round <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_fsm   <= S_RUN;
                        r_state <= state_i;
                        r_round <= w_first;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        // state_o and round_o keep the last result
                        r_fsm   <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_state <= w_next;
                    // >= guards against a corrupted index ever walking past 11
                    if (r_round >= IDX_EXIT) begin
                        r_fsm   <= S_DONE;
                        r_round <= IDX_LAST;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_round <= r_round + IDX_STEP;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_fsm  <= S_IDLE;
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = r_state;
    assign round_o = r_round;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

endmodule

// File: tb/tb_ascon_permutation_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for ascon_permutation_ctrl.
// The reference model describes the permutation as a 5-bit S-box table applied
// column by column plus word rotations, and the sequencing as "k cycles after
// an accepted start the state has had k rounds applied". One compare process
// checks all outputs against that model on every falling clock edge; directed
// tests add latency, spacing, reset and result checks.
// -----------------------------------------------------------------------------
module tb_ascon_permutation_ctrl;

`ifdef ASCON_PERM_UNROLL2_EN
    localparam int R = 2;
`else
    localparam int R = 1;
`endif

    logic             clock_i = 1'b0;
    logic             reset_i = 1'b0;
    logic             start_i = 1'b0;
    logic             mode_i  = 1'b0;
    logic [0:4][63:0] state_i = '0;
    logic [0:4][63:0] state_o;
    logic [3:0]       round_o;
    logic             busy_o;
    logic             done_o;

    ascon_permutation_ctrl dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .start_i (start_i),
        .mode_i  (mode_i),
        .state_i (state_i),
        .state_o (state_o),
        .round_o (round_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clock_i = ~clock_i;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_done = 0;
    logic cmp_en = 1'b0;

    // Ascon S-box, column value {x0,x1,x2,x3,x4} with x0 as MSB
    int sbox_tab [0:31] = '{4, 11, 31, 20, 26, 21, 9, 2, 27, 5, 8, 18, 29, 3, 6, 28,
                            30, 19, 7, 14, 0, 13, 17, 24, 16, 12, 1, 25, 22, 10, 15, 23};
    int rot_a [0:4] = '{19, 61, 1, 10, 7};
    int rot_b [0:4] = '{28, 39, 6, 17, 41};

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] m_rc(input int idx);
        return 8'((15 - idx) * 16 + idx);
    endfunction

    function automatic logic [63:0] m_ror(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x};
        return d[n +: 64];
    endfunction

    function automatic logic [0:4][63:0] m_sbox_layer(input logic [0:4][63:0] s);
        logic [0:4][63:0] t;
        logic [4:0] v, o;
        for (int b = 0; b < 64; b++) begin
            v = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
            o = 5'(sbox_tab[v]);
            for (int w = 0; w < 5; w++) t[w][b] = o[4 - w];
        end
        return t;
    endfunction

    function automatic logic [0:4][63:0] m_linear(input logic [0:4][63:0] s);
        logic [0:4][63:0] t;
        for (int w = 0; w < 5; w++)
            t[w] = s[w] ^ m_ror(s[w], rot_a[w]) ^ m_ror(s[w], rot_b[w]);
        return t;
    endfunction

    function automatic logic [0:4][63:0] m_perm(input logic [0:4][63:0] s, input int first, input int count);
        logic [0:4][63:0] t;
        t = s;
        for (int r = 0; r < count; r++) begin
            t[2] = t[2] ^ {56'd0, m_rc(first + r)};
            t = m_linear(m_sbox_layer(t));
        end
        return t;
    endfunction

    // Model of the sequencing: m_t cycles since the accepted start
    logic             m_active = 1'b0;
    int               m_t = 0;
    int               m_n = 12;
    logic [0:4][63:0] m_s0 = '0;
    logic [0:4][63:0] m_hold_state = '0;
    logic [3:0]       m_hold_round = 4'd0;

    always @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            m_active     <= 1'b0;
            m_t          <= 0;
            m_hold_state <= '0;
            m_hold_round <= 4'd0;
        end else if (start_i && !(m_active && m_t < m_n / R)) begin
            m_active <= 1'b1;
            m_t      <= 0;
            m_n      <= mode_i ? 6 : 12;
            m_s0     <= state_i;
        end else if (m_active && m_t < m_n / R) begin
            m_t <= m_t + 1;
        end else if (m_active) begin
            m_active     <= 1'b0;
            m_hold_state <= m_perm(m_s0, 12 - m_n, m_n);
            m_hold_round <= 4'd11;
        end
    end

    always @(posedge clock_i) cyc <= cyc + 1;

    always @(negedge clock_i) if (done_o === 1'b1) n_done++;

    logic [0:4][63:0] e_state;
    logic [3:0]       e_round;
    logic             e_busy, e_done;

    // Per-cycle compare of every output against the model
    always @(negedge clock_i) begin
        if (cmp_en) begin
            if (m_active) begin
                e_done  = (m_t == m_n / R);
                e_busy  = (m_t < m_n / R);
                e_state = m_perm(m_s0, 12 - m_n, m_t * R);
                e_round = e_done ? 4'd11 : 4'(12 - m_n + m_t * R);
            end else begin
                e_done  = 1'b0;
                e_busy  = 1'b0;
                e_state = m_hold_state;
                e_round = m_hold_round;
            end
            chk("cyc_state", state_o, e_state);
            chk("cyc_round", round_o, e_round);
            chk("cyc_busy",  busy_o,  e_busy);
            chk("cyc_done",  done_o,  e_done);
        end
    end

    task automatic start_perm(input logic m, input logic [0:4][63:0] s, output int e0);
        @(negedge clock_i);
        start_i = 1'b1;
        mode_i  = m;
        state_i = s;
        e0      = cyc + 1;
        @(negedge clock_i);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget, output int at_cyc);
        int k;
        k = 0;
        while (done_o !== 1'b1 && k < budget) begin
            @(negedge clock_i);
            k++;
        end
        chk({nm, "_seen"}, done_o, 1);
        at_cyc = cyc;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_state"}, state_o, 0);
        chk({nm, "_round"}, round_o, 0);
        chk({nm, "_busy"},  busy_o,  0);
        chk({nm, "_done"},  done_o,  0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [0:4][63:0] tv, tv2, tmp, pin;
    int e0, d1, d2, k, saved, tgt, p2;

    initial begin
        tv  = {64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
               64'h0001020304050607, 64'h08090a0b0c0d0e0f};
        tv2 = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0000000000000000,
               64'hffffffffffffffff, 64'h5555aaaa5555aaaa};

        // Hand-computed pins for the model itself
        chk("pin_rc0",  m_rc(0),  8'hF0);
        chk("pin_rc6",  m_rc(6),  8'h96);
        chk("pin_rc11", m_rc(11), 8'h4B);
        tmp = tv;
        tmp[2] = tmp[2] ^ {56'd0, m_rc(0)};
        chk("pin_x2_after_const", tmp[2], 64'h08090a0b0c0d0eff);
        tmp = {64'd0, 64'd0, 64'h4B, 64'd0, 64'd0};
        pin = {64'h4B, 64'h4B, ~64'h4B, 64'h4B, 64'd0};
        chk("pin_sbox_layer", m_sbox_layer(tmp), pin);
        tmp = {64'd1, 64'd0, 64'd1, 64'd0, 64'd0};
        pin = {64'h0000201000000001, 64'd0, 64'h8400000000000001, 64'd0, 64'd0};
        chk("pin_linear", m_linear(tmp), pin);

        // Asynchronous reset, before any clock edge
        #1 reset_i = 1'b1;
        #2 chk_zero("reset");
        @(negedge clock_i);
        reset_i = 1'b0;
        cmp_en  = 1'b1;

        // p^a on the reference state
        start_perm(1'b0, tv, e0);
        wait_done("pa", 40, d1);
        chk("pa_latency", d1 - e0, 12 / R);
        chk("pa_result", state_o, m_perm(tv, 0, 12));
        @(negedge clock_i);
        chk("pa_done_width", done_o, 0);
        chk("pa_result_held", state_o, m_perm(tv, 0, 12));

        // p^b on the same state
        start_perm(1'b1, tv, e0);
        wait_done("pb", 40, d1);
        chk("pb_latency", d1 - e0, 6 / R);
        chk("pb_result", state_o, m_perm(tv, 6, 6));

        // Starts while busy (with new inputs) are ignored
        p2 = (R == 1) ? 7 : 5;
        start_perm(1'b0, tv, e0);
        for (int j = 2; j <= p2; j++) begin
            @(negedge clock_i);
            start_i = (j == 3 || j == p2);
            mode_i  = 1'b1;
            state_i = tv2;
        end
        @(negedge clock_i);
        start_i = 1'b0;
        wait_done("ign", 40, d1);
        chk("ign_latency", d1 - e0, 12 / R);
        chk("ign_result", state_o, m_perm(tv, 0, 12));

        // start held through DONE: back-to-back acceptance
        @(negedge clock_i);
        start_i = 1'b1;
        mode_i  = 1'b0;
        state_i = tv;
        e0      = cyc + 1;
        @(negedge clock_i);
        state_i = tv2;
        wait_done("b2b_first", 40, d1);
        chk("b2b_first_result", state_o, m_perm(tv, 0, 12));
        @(negedge clock_i);
        start_i = 1'b0;
        chk("b2b_no_bubble", busy_o, 1);
        wait_done("b2b_second", 40, d2);
        chk("b2b_spacing", d2 - d1, 12 / R + 1);
        chk("b2b_second_result", state_o, m_perm(tv2, 0, 12));

        // Reset in the middle of a p^a run
        tgt = (R == 1) ? 5 : 4;
        start_perm(1'b0, tv, e0);
        k = 0;
        while (!(round_o === 4'(tgt) && busy_o === 1'b1) && k < 30) begin
            @(negedge clock_i);
            k++;
        end
        chk("rst_reach_idx", round_o, tgt);
        saved = n_done;
        #2 reset_i = 1'b1;
        #1 chk_zero("rst_mid");
        @(negedge clock_i);
        reset_i = 1'b0;
        repeat (3) @(negedge clock_i);
        chk("rst_no_done", n_done, saved);
        chk_zero("rst_idle");

        // Normal operation after the aborted run
        start_perm(1'b1, tv2, e0);
        wait_done("post_rst", 40, d1);
        chk("post_rst_latency", d1 - e0, 6 / R);
        chk("post_rst_result", state_o, m_perm(tv2, 6, 6));

        repeat (4) @(negedge clock_i);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
